// File: rtl/mc_pkg.sv
// Shared encodings for the multi-cycle RV32I controller: FSM states, instruction
// classes, opcodes and the datapath select/ALU codes.
package mc_pkg;

   localparam logic [2:0] ST_FETCH     = 3'd0;
   localparam logic [2:0] ST_DECODE    = 3'd1;
   localparam logic [2:0] ST_EXECUTE   = 3'd2;
   localparam logic [2:0] ST_MEMORY    = 3'd3;
   localparam logic [2:0] ST_WRITEBACK = 3'd4;

   typedef enum logic [3:0] {
      CL_R,
      CL_IALU,
      CL_LOAD,
      CL_STORE,
      CL_BRANCH,
      CL_JAL,
      CL_JALR,
      CL_LUI,
      CL_AUIPC,
      CL_ILLEGAL
   } instr_class_e;

   localparam logic [6:0] OPC_R      = 7'b0110011;
   localparam logic [6:0] OPC_IALU   = 7'b0010011;
   localparam logic [6:0] OPC_LOAD   = 7'b0000011;
   localparam logic [6:0] OPC_STORE  = 7'b0100011;
   localparam logic [6:0] OPC_BRANCH = 7'b1100011;
   localparam logic [6:0] OPC_JAL    = 7'b1101111;
   localparam logic [6:0] OPC_JALR   = 7'b1100111;
   localparam logic [6:0] OPC_LUI    = 7'b0110111;
   localparam logic [6:0] OPC_AUIPC  = 7'b0010111;

   localparam logic [1:0] OP1_RS1    = 2'd0;
   localparam logic [1:0] OP1_OLD_PC = 2'd1;
   localparam logic [1:0] OP1_ZERO   = 2'd2;

   localparam logic [1:0] WB_ALU     = 2'd0;
   localparam logic [1:0] WB_MEM     = 2'd1;
   localparam logic [1:0] WB_PC4     = 2'd2;

   localparam logic [2:0] IMM_I      = 3'd0;
   localparam logic [2:0] IMM_S      = 3'd1;
   localparam logic [2:0] IMM_B      = 3'd2;
   localparam logic [2:0] IMM_U      = 3'd3;
   localparam logic [2:0] IMM_J      = 3'd4;

   localparam logic [2:0] BR_NONE    = 3'd0;
   localparam logic [2:0] BR_BEQ     = 3'd1;
   localparam logic [2:0] BR_BNE     = 3'd2;
   localparam logic [2:0] BR_BLT     = 3'd3;
   localparam logic [2:0] BR_BGE     = 3'd4;
   localparam logic [2:0] BR_BLTU    = 3'd5;
   localparam logic [2:0] BR_BGEU    = 3'd6;
   localparam logic [2:0] BR_ALWAYS  = 3'd7;

   localparam logic [3:0] ALU_ADD    = 4'd0;
   localparam logic [3:0] ALU_SUB    = 4'd1;
   localparam logic [3:0] ALU_SLL    = 4'd2;
   localparam logic [3:0] ALU_SLT    = 4'd3;
   localparam logic [3:0] ALU_SLTU   = 4'd4;
   localparam logic [3:0] ALU_XOR    = 4'd5;
   localparam logic [3:0] ALU_SRL    = 4'd6;
   localparam logic [3:0] ALU_SRA    = 4'd7;
   localparam logic [3:0] ALU_OR     = 4'd8;
   localparam logic [3:0] ALU_AND    = 4'd9;
   localparam logic [3:0] ALU_PASS_B = 4'd10;

   // alt selects SUB for func3=0 and SRA for func3=5
   function automatic logic [3:0] alu_from_f3(input logic [2:0] f3, input logic alt);
      logic [3:0] op;
      case (f3)
         3'd0:    op = alt ? ALU_SUB : ALU_ADD;
         3'd1:    op = ALU_SLL;
         3'd2:    op = ALU_SLT;
         3'd3:    op = ALU_SLTU;
         3'd4:    op = ALU_XOR;
         3'd5:    op = alt ? ALU_SRA : ALU_SRL;
         3'd6:    op = ALU_OR;
         default: op = ALU_AND;
      endcase
      return op;
   endfunction

endpackage

// File: rtl/mc_decoder.sv
// Combinational instruction classifier: opcode/func3/func7[5] to class, ALU op,
// immediate format and branch type.
module mc_decoder
   import mc_pkg::*;
(
   input  logic [6:0]   opcode,
   input  logic [2:0]   func3,
   input  logic         func7_b5,
   output instr_class_e cls,
   output logic [3:0]   alu_ctrl,
   output logic [2:0]   imm_sel,
   output logic [2:0]   br_type
);

   always_comb begin
      cls      = CL_ILLEGAL;
      alu_ctrl = ALU_ADD;
      imm_sel  = IMM_I;
      br_type  = BR_NONE;
      case (opcode)
         OPC_R: begin
            cls      = CL_R;
            alu_ctrl = alu_from_f3(func3, func7_b5);
         end
         OPC_IALU: begin
            cls      = CL_IALU;
            alu_ctrl = alu_from_f3(func3, (func3 == 3'd5) && func7_b5);
         end
         OPC_LOAD: begin
            if (func3 inside {3'd0, 3'd1, 3'd2, 3'd4, 3'd5})
               cls = CL_LOAD;
         end
         OPC_STORE: begin
            imm_sel = IMM_S;
            if (func3 <= 3'd2)
               cls = CL_STORE;
         end
         OPC_BRANCH: begin
            imm_sel = IMM_B;
            case (func3)
               3'd0:    begin cls = CL_BRANCH; br_type = BR_BEQ;  end
               3'd1:    begin cls = CL_BRANCH; br_type = BR_BNE;  end
               3'd4:    begin cls = CL_BRANCH; br_type = BR_BLT;  end
               3'd5:    begin cls = CL_BRANCH; br_type = BR_BGE;  end
               3'd6:    begin cls = CL_BRANCH; br_type = BR_BLTU; end
               3'd7:    begin cls = CL_BRANCH; br_type = BR_BGEU; end
               default: cls = CL_ILLEGAL;
            endcase
         end
         OPC_JAL: begin
            cls     = CL_JAL;
            imm_sel = IMM_J;
         end
         OPC_JALR:  cls = CL_JALR;
         OPC_LUI: begin
            cls      = CL_LUI;
            imm_sel  = IMM_U;
            alu_ctrl = ALU_PASS_B;
         end
         OPC_AUIPC: begin
            cls     = CL_AUIPC;
            imm_sel = IMM_U;
         end
         default:   cls = CL_ILLEGAL;
      endcase
   end

endmodule

// File: rtl/multicycle_controller.sv
// Five-state multi-cycle sequencer for the RV32I datapath with retire counter.
// Define MC_MEM_WAIT_EN to add the mem_ready handshake on FETCH and MEMORY.
//
// state      | meaning
// FETCH      | read memory at PC, latch IR and old_pc
// DECODE     | classify IR; illegal opcodes skip to next PC here
// EXECUTE    | drive ALU operands; branches and jumps load the PC
// MEMORY     | load read or store write at ALU result
// WRITEBACK  | register-file write, PC+4 for non-jumps
module multicycle_controller
   import mc_pkg::*;
(
   input  logic        clk,
   input  logic        reset,
   input  logic [6:0]  opcode,
   input  logic [2:0]  func3,
   input  logic [6:0]  func7,
   input  logic        br_taken,
`ifdef MC_MEM_WAIT_EN
   input  logic        mem_ready,
`endif
   output logic        pc_write,
   output logic        pc_sel,
   output logic        ir_write,
   output logic        mem_read,
   output logic        mem_write,
   output logic        rfwrite,
   output logic [1:0]  op1_sel,
   output logic        op2_sel,
   output logic [1:0]  wb_sel,
   output logic [2:0]  imm_sel,
   output logic [2:0]  br_type,
   output logic [3:0]  ALU_Control,
   output logic        illegal_instr,
   output logic [31:0] instret
);

   logic [2:0]   state_q, state_d;
   logic [31:0]  instret_q, instret_d;
   logic         illegal_q, illegal_d;
   logic         mem_ok;
   logic         retire;
   logic         alu_drive;
   instr_class_e cls;
   logic [3:0]   dec_alu;
   logic [2:0]   dec_imm;
   logic [2:0]   dec_br;
   logic         unused_func7;

`ifdef MC_MEM_WAIT_EN
   assign mem_ok = mem_ready;
`else
   assign mem_ok = 1'b1;
`endif

   // only func7[5] distinguishes RV32I operations
   assign unused_func7 = ^{func7[6], func7[4:0]};

   mc_decoder u_decoder (
      .opcode   (opcode),
      .func3    (func3),
      .func7_b5 (func7[5]),
      .cls      (cls),
      .alu_ctrl (dec_alu),
      .imm_sel  (dec_imm),
      .br_type  (dec_br)
   );

   always_comb begin
      state_d     = state_q;
      instret_d   = instret_q;
      illegal_d   = illegal_q;
      retire      = 1'b0;
      alu_drive   = 1'b0;
      pc_write    = 1'b0;
      pc_sel      = 1'b0;
      ir_write    = 1'b0;
      mem_read    = 1'b0;
      mem_write   = 1'b0;
      rfwrite     = 1'b0;
      op1_sel     = OP1_RS1;
      op2_sel     = 1'b0;
      wb_sel      = WB_ALU;
      imm_sel     = IMM_I;
      br_type     = BR_NONE;
      ALU_Control = ALU_ADD;

      case (state_q)
         ST_FETCH: begin
            mem_read = 1'b1;
            ir_write = 1'b1;
            if (mem_ok)
               state_d = ST_DECODE;
         end
         ST_DECODE: begin
            if (cls == CL_ILLEGAL) begin
               illegal_d = 1'b1;
               pc_write  = 1'b1;
               state_d   = ST_FETCH;
            end else begin
               state_d   = ST_EXECUTE;
            end
         end
         ST_EXECUTE: begin
            alu_drive = 1'b1;
            case (cls)
               CL_BRANCH: begin
                  br_type  = dec_br;
                  pc_write = 1'b1;
                  pc_sel   = br_taken;
                  retire   = 1'b1;
                  state_d  = ST_FETCH;
               end
               CL_JAL, CL_JALR: begin
                  pc_write = 1'b1;
                  pc_sel   = 1'b1;
                  state_d  = ST_WRITEBACK;
               end
               CL_LOAD, CL_STORE: state_d = ST_MEMORY;
               default:           state_d = ST_WRITEBACK;
            endcase
         end
         ST_MEMORY: begin
            // ALU operands held so the address stays valid across wait states
            alu_drive = 1'b1;
            if (cls == CL_LOAD) begin
               mem_read = 1'b1;
               if (mem_ok)
                  state_d = ST_WRITEBACK;
            end else if (cls == CL_STORE) begin
               mem_write = 1'b1;
               if (mem_ok) begin
                  pc_write = 1'b1;
                  retire   = 1'b1;
                  state_d  = ST_FETCH;
               end
            end else begin
               state_d = ST_FETCH;
            end
         end
         ST_WRITEBACK: begin
            alu_drive = 1'b1;
            rfwrite   = 1'b1;
            retire    = 1'b1;
            state_d   = ST_FETCH;
            case (cls)
               CL_LOAD:         wb_sel = WB_MEM;
               CL_JAL, CL_JALR: wb_sel = WB_PC4;
               default:         wb_sel = WB_ALU;
            endcase
            if (cls != CL_JAL && cls != CL_JALR)
               pc_write = 1'b1;
         end
         default: state_d = ST_FETCH;
      endcase

      if (alu_drive) begin
         imm_sel     = dec_imm;
         ALU_Control = dec_alu;
         op2_sel     = (cls != CL_R);
         case (cls)
            CL_BRANCH, CL_JAL, CL_AUIPC: op1_sel = OP1_OLD_PC;
            CL_LUI:                      op1_sel = OP1_ZERO;
            default:                     op1_sel = OP1_RS1;
         endcase
      end

      if (retire)
         instret_d = instret_q + 32'd1;

      // reset silences every strobe and select in the same cycle
      if (reset) begin
         pc_write    = 1'b0;
         pc_sel      = 1'b0;
         ir_write    = 1'b0;
         mem_read    = 1'b0;
         mem_write   = 1'b0;
         rfwrite     = 1'b0;
         op1_sel     = OP1_RS1;
         op2_sel     = 1'b0;
         wb_sel      = WB_ALU;
         imm_sel     = IMM_I;
         br_type     = BR_NONE;
         ALU_Control = ALU_ADD;
      end
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         state_q   <= ST_FETCH;
         instret_q <= 32'd0;
         illegal_q <= 1'b0;
      end else begin
         state_q   <= state_d;
         instret_q <= instret_d;
         illegal_q <= illegal_d;
      end
   end

   assign instret       = instret_q;
   assign illegal_instr = illegal_q;

endmodule

// File: tb/tb_multicycle_controller.sv
// Instruction-level bench for multicycle_controller: each instruction is run from
// FETCH to the next FETCH and its strobe profile is compared with a class model.
module tb_multicycle_controller;

   logic        clk = 1'b0;
   logic        reset;
   logic [6:0]  opcode;
   logic [2:0]  func3;
   logic [6:0]  func7;
   logic        br_taken;
`ifdef MC_MEM_WAIT_EN
   logic        mem_ready;
`endif
   logic        pc_write, pc_sel, ir_write, mem_read, mem_write, rfwrite;
   logic [1:0]  op1_sel;
   logic        op2_sel;
   logic [1:0]  wb_sel;
   logic [2:0]  imm_sel, br_type;
   logic [3:0]  ALU_Control;
   logic        illegal_instr;
   logic [31:0] instret;

   int          checks = 0;
   int          failures = 0;
   logic [31:0] exp_instret;
   logic        exp_ill;

   multicycle_controller dut (
      .clk(clk), .reset(reset), .opcode(opcode), .func3(func3), .func7(func7),
      .br_taken(br_taken),
`ifdef MC_MEM_WAIT_EN
      .mem_ready(mem_ready),
`endif
      .pc_write(pc_write), .pc_sel(pc_sel), .ir_write(ir_write),
      .mem_read(mem_read), .mem_write(mem_write), .rfwrite(rfwrite),
      .op1_sel(op1_sel), .op2_sel(op2_sel), .wb_sel(wb_sel), .imm_sel(imm_sel),
      .br_type(br_type), .ALU_Control(ALU_Control),
      .illegal_instr(illegal_instr), .instret(instret)
   );

   always #5 clk = ~clk;

   // bench-side instruction classes
   localparam int K_R = 0, K_I = 1, K_LD = 2, K_ST = 3, K_BR = 4, K_JAL = 5,
                  K_JALR = 6, K_LUI = 7, K_AUIPC = 8, K_ILL = 9;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         failures++;
         $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
      end
   endtask

   function automatic int classify(input logic [6:0] op, input logic [2:0] f3);
      case (op)
         7'h33: return K_R;
         7'h13: return K_I;
         7'h03: return (f3 == 3 || f3 > 5) ? K_ILL : K_LD;
         7'h23: return (f3 > 2) ? K_ILL : K_ST;
         7'h63: return (f3 == 2 || f3 == 3) ? K_ILL : K_BR;
         7'h6F: return K_JAL;
         7'h67: return K_JALR;
         7'h37: return K_LUI;
         7'h17: return K_AUIPC;
         default: return K_ILL;
      endcase
   endfunction

   function automatic int exp_alu(input int k, input logic [2:0] f3, input logic b5);
      int tbl[8] = '{0, 2, 3, 4, 5, 6, 8, 9};
      if (k == K_LUI) return 10;
      if (k != K_R && k != K_I) return 0;
      if (f3 == 0 && k == K_R && b5) return 1;
      if (f3 == 5 && b5) return 7;
      return tbl[f3];
   endfunction

   function automatic int exp_br(input logic [2:0] f3);
      case (f3)
         3'd0: return 1;
         3'd1: return 2;
         3'd4: return 3;
         3'd5: return 4;
         3'd6: return 5;
         default: return 6;
      endcase
   endfunction

   // Entered just after a negedge with the DUT in FETCH; returns at the next FETCH.
   task automatic run_instr(input string nm, input logic [6:0] op, input logic [2:0] f3,
                            input logic [6:0] f7, input logic bt, input int waits);
      int cyc = 0, wl = waits, k, w, lat;
      int n_rf = 0, rf_idx = -1, n_pcw = 0, pcw_idx = -1, n_mr = 0, n_mw = 0, n_irw = 0;
      logic [1:0] wb_at = 0, op1_ex = 0;
      logic pcs_at = 0, op2_ex = 0;
      logic [2:0] imm_ex = 0, br_ex = 0;
      logic [3:0] alu_ex = 0;
      logic [31:0] ir_last;
      logic jump;
      opcode = op; func3 = f3; func7 = f7; br_taken = bt;
      ir_last = instret;
      forever begin
`ifdef MC_MEM_WAIT_EN
         mem_ready = 1'b1;
         if (((mem_read && !ir_write) || mem_write) && wl > 0) begin
            mem_ready = 1'b0;
            wl--;
         end
`endif
         #1;
         if (rfwrite)   begin n_rf++;  rf_idx = cyc;  wb_at = wb_sel; end
         if (pc_write)  begin n_pcw++; pcw_idx = cyc; pcs_at = pc_sel; end
         if (mem_read)  n_mr++;
         if (mem_write) n_mw++;
         if (ir_write)  n_irw++;
         if (cyc == 2) begin
            alu_ex = ALU_Control; imm_ex = imm_sel; op1_ex = op1_sel;
            op2_ex = op2_sel;     br_ex = br_type;
         end
         ir_last = instret;
         @(negedge clk);
         cyc++;
         if (ir_write || cyc >= 24) break;
      end
`ifdef MC_MEM_WAIT_EN
      mem_ready = 1'b1;
`endif
      k = classify(op, f3);
`ifdef MC_MEM_WAIT_EN
      w = (k == K_LD || k == K_ST) ? waits : 0;
`else
      w = 0;
`endif
      lat = (k == K_ILL) ? 2 : (k == K_BR) ? 3 : (k == K_LD) ? 5 + w : 4 + w;
      jump = (k == K_JAL || k == K_JALR);
      chk({nm, ".cycles"}, cyc, lat);
      chk({nm, ".rf_count"}, n_rf, (k == K_ST || k == K_BR || k == K_ILL) ? 0 : 1);
      if (n_rf == 1) begin
         chk({nm, ".rf_cycle"}, rf_idx, lat - 1);
         chk({nm, ".wb_sel"}, wb_at, (k == K_LD) ? 1 : jump ? 2 : 0);
      end
      chk({nm, ".pcw_count"}, n_pcw, 1);
      chk({nm, ".pcw_cycle"}, pcw_idx, jump ? 2 : lat - 1);
      chk({nm, ".pc_sel"}, pcs_at, (k == K_BR) ? bt : jump);
      chk({nm, ".mem_read_cnt"}, n_mr, (k == K_LD) ? 2 + w : 1);
      chk({nm, ".mem_write_cnt"}, n_mw, (k == K_ST) ? 1 + w : 0);
      chk({nm, ".ir_write_cnt"}, n_irw, 1);
      if (k != K_ILL) begin
         chk({nm, ".alu"}, alu_ex, exp_alu(k, f3, f7[5]));
         chk({nm, ".imm_sel"}, imm_ex, (k == K_ST) ? 1 : (k == K_BR) ? 2 :
                                       (k == K_LUI || k == K_AUIPC) ? 3 : (k == K_JAL) ? 4 : 0);
         chk({nm, ".op1_sel"}, op1_ex, (k == K_LUI) ? 2 :
                                       (k == K_BR || k == K_JAL || k == K_AUIPC) ? 1 : 0);
         chk({nm, ".op2_sel"}, op2_ex, (k == K_R) ? 0 : 1);
         chk({nm, ".br_type"}, br_ex, (k == K_BR) ? exp_br(f3) : 0);
      end
      chk({nm, ".instret_before_edge"}, ir_last, exp_instret);
      if (k != K_ILL) exp_instret = exp_instret + 1;
      if (k == K_ILL) exp_ill = 1'b1;
      chk({nm, ".instret"}, instret, exp_instret);
      chk({nm, ".illegal"}, illegal_instr, exp_ill);
   endtask

   logic [6:0] opc_pool [11] = '{7'h33, 7'h13, 7'h03, 7'h23, 7'h63, 7'h6F,
                                 7'h67, 7'h37, 7'h17, 7'h7F, 7'h0B};

   initial begin
      reset = 1'b1; opcode = 7'h33; func3 = 0; func7 = 0; br_taken = 1'b0;
`ifdef MC_MEM_WAIT_EN
      mem_ready = 1'b1;
`endif
      exp_instret = 0; exp_ill = 1'b0;
      repeat (3) @(negedge clk);
      #1;
      chk("reset.strobes", {pc_write, pc_sel, ir_write, mem_read, mem_write, rfwrite}, 0);
      chk("reset.selects", {op1_sel, op2_sel, wb_sel, imm_sel, br_type, ALU_Control}, 0);
      chk("reset.instret", instret, 0);
      chk("reset.illegal", illegal_instr, 0);
      @(negedge clk);
      reset = 1'b0;
      #1;
      chk("first_fetch", {ir_write, mem_read}, 2'b11);

      run_instr("add", 7'h33, 3'd0, 7'h00, 1'b0, 0);
      run_instr("beq_t", 7'h63, 3'd0, 7'h00, 1'b1, 0);
      run_instr("beq_nt", 7'h63, 3'd0, 7'h00, 1'b0, 0);
      run_instr("jalr", 7'h67, 3'd0, 7'h00, 1'b0, 0);
      run_instr("illegal7f", 7'h7F, 3'd0, 7'h00, 1'b0, 0);
      run_instr("lw_wait", 7'h03, 3'd2, 7'h00, 1'b0, 3);
      run_instr("sub", 7'h33, 3'd0, 7'h20, 1'b0, 0);
      run_instr("srai", 7'h13, 3'd5, 7'h20, 1'b0, 0);

      for (int i = 0; i < 60; i++) begin
         run_instr("rand", opc_pool[$urandom_range(0, 10)], 3'($urandom_range(0, 7)),
                   7'($urandom), 1'($urandom_range(0, 1)), $urandom_range(0, 2));
      end

      // reset while a store is in MEMORY
      opcode = 7'h23; func3 = 3'd2; func7 = 0;
      repeat (3) @(negedge clk);
      #1;
      chk("sw_abort.pre_mem_write", mem_write, 1);
      reset = 1'b1;
      #1;
      chk("sw_abort.mem_write", mem_write, 0);
      chk("sw_abort.pc_write", pc_write, 0);
      chk("sw_abort.rfwrite", rfwrite, 0);
      @(negedge clk);
      reset = 1'b0;
      #1;
      exp_instret = 0; exp_ill = 1'b0;
      chk("sw_abort.fetch_next", {ir_write, mem_read}, 2'b11);
      chk("sw_abort.instret", instret, 0);
      chk("sw_abort.illegal", illegal_instr, 0);
      run_instr("add_after_reset", 7'h33, 3'd7, 7'h00, 1'b0, 0);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
